// File: rtl/floattoint_pkg.sv
// Shared single-precision float definitions for the synth's float<->int conversion stages.
package fpgasynth_fp_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int FP_EXP_BIAS = 127;
    localparam int FP_EXP_MAX  = 255;
    localparam int FP_MANT_W   = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        SHIFT  = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } f2i_state_t;

endpackage

// File: rtl/floattoint_if.sv
// Start/done handshake bundle between a float producer and the floattoint converter.
interface floattoint_if #(
    parameter int OUT_WIDTH = 16
);
    logic                 start;
    logic [31:0]          floatin;
    logic [OUT_WIDTH-1:0] intout;
    logic                 done;
    logic                 busy;

    modport master (output start, output floatin, input intout, input done, input busy);
    modport slave  (input start, input floatin, output intout, output done, output busy);
endinterface

// File: rtl/floattoint_round.sv
// Final stage of floattoint: optional round-to-nearest-even, saturation and sign application.
// Build option: FLOATTOINT_ROUND_NEAREST_EN enables rounding; otherwise truncates toward zero.
module floattoint_round
    import fpgasynth_fp_pkg::*;
#(
    parameter int OUT_WIDTH = 16
) (
    input  logic                 sign,
    input  logic                 sat,
    input  logic [FP_MANT_W-1:0] mant,
    input  logic                 guard,
    input  logic                 sticky,
    output logic [OUT_WIDTH-1:0] result
);
    localparam logic [FP_MANT_W:0]   MAG_LIMIT = (FP_MANT_W + 1)'(1) << (OUT_WIDTH - 1);
    localparam logic [OUT_WIDTH-1:0] POS_MAX   = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] NEG_MIN   = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    logic             inc_s;
    logic [FP_MANT_W:0] mag_s;

    // Rounding increment, magnitude and saturating signed result
    always_comb begin
        inc_s  = 1'b0;
        mag_s  = '0;
        result = '0;
`ifdef FLOATTOINT_ROUND_NEAREST_EN
        inc_s = guard & (sticky | mant[0]);
`else
        inc_s = guard & sticky & 1'b0;
`endif
        mag_s = {1'b0, mant} + {{FP_MANT_W{1'b0}}, inc_s};
        if (sat || (mag_s >= MAG_LIMIT)) begin
            result = sign ? NEG_MIN : POS_MAX;
        end else if (sign) begin
            result = OUT_WIDTH'(-mag_s);
        end else begin
            result = OUT_WIDTH'(mag_s);
        end
    end
endmodule

// File: rtl/floattoint.sv
// floattoint: multicycle IEEE-754 single -> signed OUT_WIDTH-bit integer, one shift per cycle.
// Build option: FLOATTOINT_ROUND_NEAREST_EN (handled in floattoint_round).
module floattoint
    import fpgasynth_fp_pkg::*;
#(
    parameter int OUT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    floattoint_if.slave bus
);
    f2i_state_t           state_r, state_s;
    fp32_t                fp_r;
    logic                 sign_r, guard_r, sticky_r, sat_r, done_r, busy_r;
    logic [FP_MANT_W-1:0] mant_r;
    logic [4:0]           cnt_r;
    logic [OUT_WIDTH-1:0] intout_r;

    logic signed [9:0]    exp_s;
    logic [FP_MANT_W-1:0] unp_mant_s;
    logic                 unp_sticky_s, unp_sat_s;
    logic [4:0]           unp_n_s;
    logic [OUT_WIDTH-1:0] round_result_s;

    // Classify the captured float and derive the shift distance
    always_comb begin
        exp_s        = $signed({2'b00, fp_r.exp}) - $signed(10'(FP_EXP_BIAS));
        unp_mant_s   = '0;
        unp_sticky_s = 1'b0;
        unp_sat_s    = 1'b0;
        unp_n_s      = 5'd0;
        if (fp_r.exp == 8'(FP_EXP_MAX)) begin
            unp_sat_s = (fp_r.frac == 23'd0);
        end else if (fp_r.exp == 8'd0) begin
            unp_sat_s = 1'b0;
        end else if (exp_s < -10'sd1) begin
            unp_sticky_s = 1'b1;
        end else if (exp_s >= $signed(10'(OUT_WIDTH - 1))) begin
            unp_sat_s = 1'b1;
        end else begin
            unp_mant_s = {1'b1, fp_r.frac};
            unp_n_s    = 5'($signed(10'(FP_MANT_W - 1)) - exp_s);
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = bus.start ? UNPACK : IDLE;
            UNPACK:  state_s = (unp_n_s > 5'd0) ? SHIFT : ROUND;
            SHIFT:   state_s = (cnt_r == 5'd1) ? ROUND : SHIFT;
            ROUND:   state_s = DONE;
            DONE:    state_s = bus.start ? UNPACK : DONE;
            default: state_s = IDLE;
        endcase
    end

    // State, datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            fp_r     <= '0;
            sign_r   <= 1'b0;
            mant_r   <= '0;
            guard_r  <= 1'b0;
            sticky_r <= 1'b0;
            sat_r    <= 1'b0;
            cnt_r    <= 5'd0;
            intout_r <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_s == DONE);
            busy_r  <= (state_s == UNPACK) || (state_s == SHIFT) || (state_s == ROUND);
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        fp_r <= fp32_t'(bus.floatin);
                    end
                end
                UNPACK: begin
                    sign_r   <= fp_r.sign;
                    mant_r   <= unp_mant_s;
                    guard_r  <= 1'b0;
                    sticky_r <= unp_sticky_s;
                    sat_r    <= unp_sat_s;
                    cnt_r    <= unp_n_s;
                end
                SHIFT: begin
                    // The bit leaving the mantissa becomes guard; the previous guard folds into sticky
                    mant_r   <= mant_r >> 1;
                    guard_r  <= mant_r[0];
                    sticky_r <= sticky_r | guard_r;
                    cnt_r    <= cnt_r - 5'd1;
                end
                ROUND: begin
                    intout_r <= round_result_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    floattoint_round #(.OUT_WIDTH(OUT_WIDTH)) u_round (
        .sign   (sign_r),
        .sat    (sat_r),
        .mant   (mant_r),
        .guard  (guard_r),
        .sticky (sticky_r),
        .result (round_result_s)
    );

    assign bus.intout = intout_r;
    assign bus.done   = done_r;
    assign bus.busy   = busy_r;
endmodule
